pwm_generator: RTL and testbench

Counter-based PWM generator sitting directly downstream of the clock divider. It consumes the divided clock (odd or even output) as a tick source on the system clock and produces a PWM waveform with programmable period and duty. New settings are double-buffered and take effect only at a period boundary, so the output never glitches. An optional complementary output with dead-time insertion is available.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_deadtime.sv | 31 +++
 rtl/pwm_generator.sv | 96 +++++++++
 tb/tb_pwm_generator.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, FSM state and config record for the PWM generator
package pwm_pkg;
  localparam int RANGE_PWM_DEF = 12;
  localparam int DEAD_W_DEF = 4;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [RANGE_PWM_DEF-1:0] period;
    logic [RANGE_PWM_DEF-1:0] duty;
    logic [DEAD_W_DEF-1:0]    dead;
  } cfg_t;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary PWM pair, turn-on delayed by dead cycles after each raw edge (PWM_DEADTIME_EN only)
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_raw,
  input  logic [DEAD_W-1:0] dead,
  output logic              pwm_out,
  output logic              pwm_out_n
);
  logic raw_d, chg, busy;
  logic [DEAD_W-1:0] dc;
  assign chg = pwm_raw ^ raw_d;
  assign busy = chg ? dead != '0 : dc != '0;
  assign pwm_out = pwm_raw & ~busy;
  assign pwm_out_n = en & ~pwm_raw & ~busy;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      raw_d <= 1'b0;
      dc <= '0;
    end else begin
      raw_d <= pwm_raw;
      dc <= chg ? (dead != '0 ? dead - DEAD_W'(1) : '0) : (dc != '0 ? dc - DEAD_W'(1) : '0);
    end
endmodule
`endif

// File: rtl/pwm_generator.sv
// pwm_generator: double-buffered PWM counted on divider ticks; PWM_DEADTIME_EN adds pwm_out_n with dead time
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int RANGE_PWM = RANGE_PWM_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int DEAD_W = DEAD_W_DEF
`endif
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [RANGE_PWM-1:0] cfg_period,
  input  logic [RANGE_PWM-1:0] cfg_duty,
`ifdef PWM_DEADTIME_EN
  input  logic [DEAD_W-1:0]    cfg_dead,
  output logic                 pwm_out_n,
`endif
  output logic                 pwm_out,
  output logic                 period_done,
  output logic                 active
);
  state_t state, state_n;
  logic s1, s2, s3, tick, pending, xfer, load, wrap, pwm_raw, pwm_n;
  logic [RANGE_PWM-1:0] cnt, cnt_n, per_a, per_n, duty_a, duty_n, sh_per, sh_duty;
  assign tick = s2 & ~s3;
  assign xfer = cfg_valid & ~pending;
  assign cfg_ready = ~pending;
  assign active = state == RUN;
  always_comb begin
    wrap = state == RUN && per_a != '0 && cnt == per_a - RANGE_PWM'(1);
    load = tick && pending && (state == IDLE || wrap);
    per_n = load ? sh_per : per_a;
    duty_n = load ? sh_duty : duty_a;
    cnt_n = state == RUN && !wrap ? cnt + RANGE_PWM'(1) : '0;
    state_n = (state == RUN || load) && per_n != '0 ? RUN : IDLE;
    pwm_n = state_n == RUN && cnt_n < duty_n;
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {tick_in, s1, s2};
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      pending <= 1'b0;
      sh_per <= '0;
      sh_duty <= '0;
    end else begin
      pending <= xfer | (pending & ~load);
      if (xfer) begin
        sh_per <= cfg_period;
        sh_duty <= cfg_duty;
      end
    end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      per_a <= '0;
      duty_a <= '0;
      pwm_raw <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= tick & wrap;
      if (tick) begin
        state <= state_n;
        cnt <= cnt_n;
        per_a <= per_n;
        duty_a <= duty_n;
        pwm_raw <= pwm_n;
      end
    end
`ifdef PWM_DEADTIME_EN
  logic [DEAD_W-1:0] sh_dead, dead_a;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      sh_dead <= '0;
      dead_a <= '0;
    end else begin
      if (xfer) sh_dead <= cfg_dead;
      if (load) dead_a <= sh_dead;
    end
  pwm_deadtime #(.DEAD_W(DEAD_W)) u_deadtime (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (active),
    .pwm_raw   (pwm_raw),
    .dead      (dead_a),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );
`else
  assign pwm_out = pwm_raw;
`endif
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: scoreboard bench for pwm_generator, per-tick expectations popped two cycles after each tick
module tb_pwm_generator;
  logic clk_in = 1'b0, rst = 1'b1, tick_in = 1'b0, cfg_valid = 1'b0;
  logic [11:0] cfg_period = '0, cfg_duty = '0;
  logic cfg_ready, pwm_out, period_done, active;
`ifdef PWM_DEADTIME_EN
  logic [3:0] cfg_dead = '0;
  logic pwm_out_n;
`endif
  logic tprev = 1'b0;
  logic [2:0] tk = '0;
  logic [2:0] sb[$];
  logic [2:0] e;
  logic last;
  int tests = 0, fails = 0;

  pwm_generator dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .tick_in     (tick_in),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
`ifdef PWM_DEADTIME_EN
    .cfg_dead    (cfg_dead),
    .pwm_out_n   (pwm_out_n),
`endif
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .active      (active)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    tk <= {tk[1:0], tick_in & ~tprev};
    tprev <= tick_in;
  end

  task automatic apply_reset();
    @(negedge clk_in);
    rst = 1'b1;
    cfg_valid = 1'b0;
    tick_in = 1'b0;
    sb.delete();
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic load_cfg(input int p, input int d);
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_period = 12'(p);
    cfg_duty = 12'(d);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic drive_ticks(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk_in);
      tick_in = 1'b1;
      @(negedge clk_in);
      tick_in = 1'b0;
    end
  endtask

  task automatic push_seg(input int p, input int d, input int n, input bit w0);
    for (int k = 0; k < n; k++) begin
      int pos;
      pos = k % p;
      sb.push_back({pos < d, pos == 0 && (k > 0 || w0), 1'b1});
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) sb.push_back(3'b000);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    tests++;
    if ({pwm_out, period_done, active, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_values: pwm/done/active/ready got %b want 0001", {pwm_out, period_done, active, cfg_ready});
    end
`ifdef PWM_DEADTIME_EN
    tests++;
    if (pwm_out_n !== 1'b0) begin
      fails++;
      $display("FAIL reset_pwm_n: got %b want 0", pwm_out_n);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    load_cfg(4, 1);
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_ready_drop: got %b want 0", cfg_ready);
    end
    push_seg(4, 1, 12, 1'b0);
    last = 1'b0;
    fork
      drive_ticks(12);
      for (int c = 0; c < 28; c++) begin
        @(negedge clk_in);
        tests++;
        if (tk[2]) begin
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL basic_tick: unexpected tick output at cycle %0d", c);
          end else begin
            e = sb.pop_front();
            last = e[2];
            if ({pwm_out, period_done, active} !== e) begin
              fails++;
              $display("FAIL basic_tick: cycle %0d pwm/done/active got %b want %b", c, {pwm_out, period_done, active}, e);
            end
          end
        end else if ({pwm_out, period_done} !== {last, 1'b0}) begin
          fails++;
          $display("FAIL basic_hold: cycle %0d pwm/done got %b want %b", c, {pwm_out, period_done}, {last, 1'b0});
        end
      end
    join
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL basic_left: %0d expectations unconsumed, want 0", sb.size());
    end
  endtask

  task automatic test_extremes();
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      load_cfg(8, s == 0 ? 0 : 10);
      push_seg(8, s == 0 ? 0 : 10, 17, 1'b0);
      fork
        drive_ticks(17);
        for (int c = 0; c < 38; c++) begin
          @(negedge clk_in);
          if (tk[2]) begin
            tests++;
            if (sb.size() == 0) begin
              fails++;
              $display("FAIL extreme_tick: unexpected tick output duty case %0d", s);
            end else begin
              e = sb.pop_front();
              if ({pwm_out, period_done, active} !== e) begin
                fails++;
                $display("FAIL extreme_tick: case %0d cycle %0d got %b want %b", s, c, {pwm_out, period_done, active}, e);
              end
            end
          end
        end
      join
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL extreme_left: case %0d %0d unconsumed, want 0", s, sb.size());
      end
    end
  endtask

  task automatic test_shadow();
    int rise_c;
    rise_c = -1;
    apply_reset();
    load_cfg(5, 2);
    push_seg(5, 2, 10, 1'b0);
    push_seg(3, 3, 3, 1'b1);
    push_seg(7, 1, 7, 1'b1);
    fork
      drive_ticks(20);
      for (int c = 0; c < 44; c++) begin
        @(negedge clk_in);
        if (tk[2]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL shadow_tick: unexpected tick output at cycle %0d", c);
          end else begin
            e = sb.pop_front();
            if ({pwm_out, period_done, active} !== e) begin
              fails++;
              $display("FAIL shadow_tick: cycle %0d got %b want %b", c, {pwm_out, period_done, active}, e);
            end
          end
        end
        if (c == 15) begin
          cfg_valid = 1'b1;
          cfg_period = 12'd3;
          cfg_duty = 12'd3;
        end else if (c == 16) begin
          tests++;
          if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL shadow_ready_drop: got %b want 0", cfg_ready);
          end
          cfg_period = 12'd7;
          cfg_duty = 12'd1;
        end else if (c > 16 && c < 24) begin
          if (cfg_ready === 1'b1 && rise_c < 0) rise_c = c;
        end else if (c == 24) begin
          cfg_valid = 1'b0;
          tests++;
          if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL shadow_second_accept: ready got %b want 0", cfg_ready);
          end
        end
      end
    join
    tests++;
    if (rise_c != 23) begin
      fails++;
      $display("FAIL shadow_stall: ready rose at cycle %0d want 23", rise_c);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL shadow_left: %0d unconsumed, want 0", sb.size());
    end
  endtask

  task automatic test_wrap_race();
    apply_reset();
    load_cfg(4, 2);
    push_seg(4, 2, 8, 1'b0);
    push_seg(2, 1, 4, 1'b1);
    fork
      drive_ticks(12);
      for (int c = 0; c < 28; c++) begin
        @(negedge clk_in);
        if (tk[2]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL race_tick: unexpected tick output at cycle %0d", c);
          end else begin
            e = sb.pop_front();
            if ({pwm_out, period_done, active} !== e) begin
              fails++;
              $display("FAIL race_tick: cycle %0d got %b want %b", c, {pwm_out, period_done, active}, e);
            end
          end
        end
        if (c == 10) begin
          cfg_valid = 1'b1;
          cfg_period = 12'd2;
          cfg_duty = 12'd1;
        end else if (c == 11) begin
          cfg_valid = 1'b0;
          tests++;
          if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL race_accept: ready got %b want 0", cfg_ready);
          end
        end
      end
    join
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL race_left: %0d unconsumed, want 0", sb.size());
    end
  endtask

  task automatic test_disable();
    apply_reset();
    load_cfg(4, 2);
    push_seg(4, 2, 8, 1'b0);
    sb.push_back(3'b010);
    push_idle(3);
    fork
      drive_ticks(12);
      for (int c = 0; c < 28; c++) begin
        @(negedge clk_in);
        if (tk[2]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL disable_tick: unexpected tick output at cycle %0d", c);
          end else begin
            e = sb.pop_front();
            if ({pwm_out, period_done, active} !== e) begin
              fails++;
              $display("FAIL disable_tick: cycle %0d got %b want %b", c, {pwm_out, period_done, active}, e);
            end
          end
        end
        if (c == 11) begin
          cfg_valid = 1'b1;
          cfg_period = 12'd0;
          cfg_duty = 12'd2;
        end else if (c == 12) cfg_valid = 1'b0;
      end
    join
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL disable_left: %0d unconsumed, want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    load_cfg(8, 8);
    push_seg(8, 8, 4, 1'b0);
    for (int s = 0; s < 2; s++) begin
      fork
        drive_ticks(4);
        for (int c = 0; c < 12; c++) begin
          @(negedge clk_in);
          if (tk[2]) begin
            tests++;
            if (sb.size() == 0) begin
              fails++;
              $display("FAIL midrst_tick: unexpected tick output phase %0d", s);
            end else begin
              e = sb.pop_front();
              if ({pwm_out, period_done, active} !== e) begin
                fails++;
                $display("FAIL midrst_tick: phase %0d cycle %0d got %b want %b", s, c, {pwm_out, period_done, active}, e);
              end
            end
          end
        end
      join
      if (s == 0) begin
        load_cfg(2, 1);
        tests++;
        if ({cfg_ready, pwm_out} !== 2'b01) begin
          fails++;
          $display("FAIL midrst_pre: ready/pwm got %b want 01", {cfg_ready, pwm_out});
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({pwm_out, period_done, active, cfg_ready} !== 4'b0001) begin
          fails++;
          $display("FAIL midrst_async: pwm/done/active/ready got %b want 0001", {pwm_out, period_done, active, cfg_ready});
        end
`ifdef PWM_DEADTIME_EN
        tests++;
        if (pwm_out_n !== 1'b0) begin
          fails++;
          $display("FAIL midrst_pwm_n: got %b want 0", pwm_out_n);
        end
`endif
        @(negedge clk_in);
        rst = 1'b0;
        push_idle(4);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL midrst_left: %0d unconsumed, want 0", sb.size());
    end
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    int gap, ngaps;
    bit seen;
    gap = 0;
    ngaps = 0;
    seen = 1'b0;
    apply_reset();
    cfg_dead = 4'd2;
    load_cfg(8, 4);
    fork
      drive_ticks(24);
      for (int c = 0; c < 52; c++) begin
        @(negedge clk_in);
        tests++;
        if (pwm_out === 1'b1 && pwm_out_n === 1'b1) begin
          fails++;
          $display("FAIL dead_overlap: cycle %0d both outputs high, want at most one", c);
        end
        if (pwm_out === 1'b1 || pwm_out_n === 1'b1) begin
          if (seen && gap > 0) begin
            ngaps++;
            tests++;
            if (gap != 2) begin
              fails++;
              $display("FAIL dead_gap: cycle %0d both-low for %0d cycles want 2", c, gap);
            end
          end
          seen = 1'b1;
          gap = 0;
        end else gap++;
      end
    join
    tests++;
    if (ngaps < 4) begin
      fails++;
      $display("FAIL dead_edges: saw %0d dead gaps want at least 4", ngaps);
    end
    cfg_dead = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_shadow();
    test_wrap_race();
    test_disable();
    test_reset_mid_run();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
